// File: rtl/boolean_sweep_ctrl_if.sv
// boolean_sweep_ctrl_if: host and evaluator signals of the boolean sweep sequencer.
interface boolean_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] exp_f1;
  logic [15:0] exp_f2;
  logic        eval_f1;
  logic        eval_f2;
  logic [3:0]  eval_abcd;
  logic [3:0]  eval_wxyz;
  logic        busy;
  logic        done;
  logic [15:0] tt_f1;
  logic [15:0] tt_f2;
  logic [4:0]  err_cnt;
  logic [3:0]  first_fail_idx;
  logic        pass;
  logic        fail;
  modport slave (
    input  start, abort, exp_f1, exp_f2, eval_f1, eval_f2,
    output eval_abcd, eval_wxyz, busy, done, tt_f1, tt_f2, err_cnt, first_fail_idx, pass, fail
  );
  modport master (
    output start, abort, exp_f1, exp_f2, eval_f1, eval_f2,
    input  eval_abcd, eval_wxyz, busy, done, tt_f1, tt_f2, err_cnt, first_fail_idx, pass, fail
  );
endinterface

// File: rtl/boolean_sweep_ctrl.sv
// boolean_sweep_ctrl: sweeps a 4-input evaluator over all 16 indices and grades both truth tables.
module boolean_sweep_ctrl #(
  parameter int EVAL_LAT = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  boolean_sweep_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [2:0] LAT = 3'(EVAL_LAT);
  state_t      state, state_n;
  logic [3:0]  idx, ff_idx;
  logic [2:0]  wait_cnt;
  logic [15:0] exp1, exp2, tt1, tt2;
  logic [4:0]  err;
  logic        pass_r, fail_r, cap, miss, go;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  // cap marks the one cycle per index where the evaluator result is settled
  always_comb begin
    go      = state == IDLE && bus.start;
    cap     = state == RUN && !bus.abort && wait_cnt == LAT;
    miss    = bus.eval_f1 != exp1[idx] || bus.eval_f2 != exp2[idx];
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (bus.abort ? IDLE : (cap && idx == 4'd15) ? DONE : RUN) :
              IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      wait_cnt <= '0;
      exp1     <= '0;
      exp2     <= '0;
      tt1      <= '0;
      tt2      <= '0;
      err      <= '0;
      ff_idx   <= '0;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
    end else if (go) begin
      idx      <= '0;
      wait_cnt <= '0;
      exp1     <= bus.exp_f1;
      exp2     <= bus.exp_f2;
      tt1      <= '0;
      tt2      <= '0;
      err      <= '0;
      ff_idx   <= '0;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
    end else if (cap) begin
      tt1[idx] <= bus.eval_f1;
      tt2[idx] <= bus.eval_f2;
      if (miss) err <= err + 5'd1;
      if (miss && err == 5'd0) ff_idx <= idx;
      if (idx != 4'd15) idx <= idx + 4'd1;
      wait_cnt <= '0;
    end else if (state == RUN) begin
      wait_cnt <= wait_cnt + 3'd1;
    end else if (state == DONE) begin
      pass_r <= err == 5'd0;
      fail_r <= err != 5'd0;
    end
  end
  assign bus.eval_abcd      = idx;
  assign bus.eval_wxyz      = idx;
  assign bus.busy           = state != IDLE;
  assign bus.done           = state == DONE;
  assign bus.tt_f1          = tt1;
  assign bus.tt_f2          = tt2;
  assign bus.err_cnt        = err;
  assign bus.first_fail_idx = ff_idx;
  assign bus.pass           = pass_r;
  assign bus.fail           = fail_r;
endmodule
